// File: rtl/ex_mem.sv
// EX->MEM pipeline register with stall/bubble/flush and EX accumulate-state feedback.
// Optional bubble counter enabled by defining EX_MEM_BUBBLE_CNT_EN.
module ex_mem #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned CNT_W      = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  ex_stall,
   input  logic                  mem_stall,
   input  logic [REG_ADDR_W-1:0] ex_wd,
   input  logic                  ex_wreg,
   input  logic [DATA_W-1:0]     ex_wdata,
   input  logic                  ex_whilo,
   input  logic [DATA_W-1:0]     ex_hi,
   input  logic [DATA_W-1:0]     ex_lo,
   input  logic [2*DATA_W-1:0]   hilo_temp_i,
   input  logic [CNT_W-1:0]      cnt_i,
   output logic [REG_ADDR_W-1:0] mem_wd,
   output logic                  mem_wreg,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic                  mem_whilo,
   output logic [DATA_W-1:0]     mem_hi,
   output logic [DATA_W-1:0]     mem_lo,
   output logic [2*DATA_W-1:0]   hilo_temp_o,
   output logic [CNT_W-1:0]      cnt_o,
   output logic [31:0]           bubble_cnt
);

   logic [REG_ADDR_W-1:0] wd_q, wd_d;
   logic                  wreg_q, wreg_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   logic                  whilo_q, whilo_d;
   logic [DATA_W-1:0]     hi_q, hi_d;
   logic [DATA_W-1:0]     lo_q, lo_d;
   logic [2*DATA_W-1:0]   hilo_temp_q, hilo_temp_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  bubble;

   assign bubble = !flush && !mem_stall && ex_stall;

   always_comb begin
      wd_d        = wd_q;
      wreg_d      = wreg_q;
      wdata_d     = wdata_q;
      whilo_d     = whilo_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      hilo_temp_d = hilo_temp_q;
      cnt_d       = cnt_q;
      if (flush) begin
         wd_d        = '0;
         wreg_d      = 1'b0;
         wdata_d     = '0;
         whilo_d     = 1'b0;
         hi_d        = '0;
         lo_d        = '0;
         hilo_temp_d = '0;
         cnt_d       = '0;
      end else if (mem_stall) begin
         // MEM frozen: keep every register as is
      end else if (ex_stall) begin
         // Insert a nop into MEM but keep EX multi-cycle progress alive
         wd_d        = '0;
         wreg_d      = 1'b0;
         wdata_d     = '0;
         whilo_d     = 1'b0;
         hi_d        = '0;
         lo_d        = '0;
         hilo_temp_d = hilo_temp_i;
         cnt_d       = cnt_i;
      end else begin
         wd_d        = ex_wd;
         wreg_d      = ex_wreg;
         wdata_d     = ex_wdata;
         whilo_d     = ex_whilo;
         hi_d        = ex_hi;
         lo_d        = ex_lo;
         hilo_temp_d = '0;
         cnt_d       = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_q        <= '0;
         wreg_q      <= 1'b0;
         wdata_q     <= '0;
         whilo_q     <= 1'b0;
         hi_q        <= '0;
         lo_q        <= '0;
         hilo_temp_q <= '0;
         cnt_q       <= '0;
      end else begin
         wd_q        <= wd_d;
         wreg_q      <= wreg_d;
         wdata_q     <= wdata_d;
         whilo_q     <= whilo_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         hilo_temp_q <= hilo_temp_d;
         cnt_q       <= cnt_d;
      end
   end

`ifdef EX_MEM_BUBBLE_CNT_EN
   logic [31:0] bubble_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         bubble_cnt_q <= '0;
      end else if (bubble) begin
         bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
   end

   assign bubble_cnt = bubble_cnt_q;
`else
   logic unused_bubble;
   assign unused_bubble = bubble;
   assign bubble_cnt    = 32'h0;
`endif

   assign mem_wd      = wd_q;
   assign mem_wreg    = wreg_q;
   assign mem_wdata   = wdata_q;
   assign mem_whilo   = whilo_q;
   assign mem_hi      = hi_q;
   assign mem_lo      = lo_q;
   assign hilo_temp_o = hilo_temp_q;
   assign cnt_o       = cnt_q;

endmodule
